// File: rtl/piso_shift_pkg.sv
// ============================================================================
// piso_pkg : shared types and helpers for the PISO transmitter and its
//            serial bit counter.  Revision 1.0
// ============================================================================
`default_nettype none

package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_if.sv
// ============================================================================
// piso_shift_if : load handshake plus serial output bundle of piso_shift.
//                 Revision 1.0
// ============================================================================
`default_nettype none

interface piso_shift_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] din;
  logic             sdo;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, din,
    input  load_ready, sdo, busy, done
  );

  modport slave (
    input  load_valid, din,
    output load_ready, sdo, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/piso_shift_bit_cnt.sv
// ============================================================================
// piso_bit_cnt : loadable down-counter with zero flag; holds at zero rather
//                than wrapping.  Revision 1.0
// ============================================================================
`default_nettype none

module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int CW = clog2(DEFAULT_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          dec_i,
  input  logic [CW-1:0] load_val_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/piso_shift.sv
// ============================================================================
// piso_shift : parallel-in serial-out transmitter with valid/ready load and
//              back-to-back words.  Optional macro PISO_PARITY_EN appends an
//              even-parity bit per word.  Revision 1.0
// ============================================================================
`default_nettype none

module piso_shift
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic         clk,
  input  logic         r,
  piso_shift_if.slave  bus
);

  localparam int            CW        = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sdo_q, sdo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             cnt_load;
  logic             cnt_dec;
  logic [CW-1:0]    cnt_q;
  logic             cnt_zero;
  logic             load_ready;
  logic             accept;

  logic             first_bit;
  logic [WIDTH-1:0] load_rest;
  logic             shift_bit;
  logic [WIDTH-1:0] shift_rest;

  piso_bit_cnt #(
    .CW (CW)
  ) u_bit_cnt (
    .clk        (clk),
    .rst        (r),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (LAST_LOAD),
    .cnt_o      (cnt_q),
    .zero_o     (cnt_zero)
  );

  // The register always presents the next bit to send at one fixed end.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit  = bus.din[WIDTH-1];
      load_rest  = {bus.din[WIDTH-2:0], 1'b0};
      shift_bit  = shreg_q[WIDTH-1];
      shift_rest = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      first_bit  = bus.din[0];
      load_rest  = {1'b0, bus.din[WIDTH-1:1]};
      shift_bit  = shreg_q[0];
      shift_rest = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    sdo_d      = sdo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    load_ready = 1'b0;
`ifdef PISO_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        if (!cnt_zero) begin
          shreg_d = shift_rest;
          sdo_d   = shift_bit;
          cnt_dec = 1'b1;
`ifndef PISO_PARITY_EN
          done_d  = (cnt_q == CW'(1));
`endif
        end else begin
`ifdef PISO_PARITY_EN
          state_d = PAR;
          sdo_d   = par_q;
          done_d  = 1'b1;
`else
          load_ready = 1'b1;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        load_ready = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
        sdo_d   = IDLE_LVL;
        busy_d  = 1'b0;
      end
    endcase

    // A word's final cycle either reloads seamlessly or drops back to idle.
    accept = bus.load_valid && load_ready;
    if (accept) begin
      state_d  = SHIFT;
      shreg_d  = load_rest;
      sdo_d    = first_bit;
      busy_d   = 1'b1;
      cnt_load = 1'b1;
`ifdef PISO_PARITY_EN
      par_d    = ^bus.din;
`endif
    end else if (load_ready && (state_q != IDLE)) begin
      state_d = IDLE;
      sdo_d   = IDLE_LVL;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      shreg_q <= '0;
      sdo_q   <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sdo        = sdo_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_shift.sv
// ============================================================================
// tb_piso_shift : directed self-checking bench for piso_shift (WIDTH=4,
//                 MSB first, idle level 0).  Revision 1.0
// ============================================================================
`default_nettype none

module tb_piso_shift;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       r;
  logic [3:0] cap;
  int         checks = 0;
  int         errors = 0;

  piso_shift_if #(.WIDTH(W)) bus ();

  piso_shift #(
    .WIDTH     (W),
    .MSB_FIRST (1'b1),
    .IDLE_LVL  (1'b0)
  ) u_dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Receiver model: 4-stage capture chain sampling on the falling edge.
  always @(negedge clk) cap <= {cap[2:0], bus.sdo};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_sdo"},   bus.sdo,        1'b0);
    chk({tag, "_busy"},  bus.busy,       1'b0);
    chk({tag, "_done"},  bus.done,       1'b0);
    chk({tag, "_ready"}, bus.load_ready, 1'b1);
  endtask

  // Caller has already presented w; the load is accepted at the first edge.
  task automatic word_bits(input string tag, input logic [3:0] w,
                           input logic nv, input logic [3:0] nd);
    logic last;
    for (int i = 0; i < W; i++) begin
      step();
      if (i == 0) begin
        bus.load_valid = nv;
        bus.din        = nd;
      end
      last = (i == W - 1) && !PAR_EN;
      chk($sformatf("%s_sdo%0d", tag, i),   bus.sdo,        w[W-1-i]);
      chk($sformatf("%s_busy%0d", tag, i),  bus.busy,       1'b1);
      chk($sformatf("%s_done%0d", tag, i),  bus.done,       last);
      chk($sformatf("%s_ready%0d", tag, i), bus.load_ready, last);
    end
`ifdef PISO_PARITY_EN
    step();
    chk({tag, "_par_sdo"},   bus.sdo,        ^w);
    chk({tag, "_par_busy"},  bus.busy,       1'b1);
    chk({tag, "_par_done"},  bus.done,       1'b1);
    chk({tag, "_par_ready"}, bus.load_ready, 1'b1);
`endif
  endtask

  initial begin
    r              = 1'b1;
    bus.load_valid = 1'b0;
    bus.din        = 4'h0;
    repeat (3) step();
    idle_chk("reset");

    r = 1'b0;
    repeat (2) step();
    idle_chk("idle_after_release");

    // Single word 1011
    bus.load_valid = 1'b1;
    bus.din        = 4'b1011;
    chk("pre_accept_ready", bus.load_ready, 1'b1);
    word_bits("w1011", 4'b1011, 1'b0, 4'h0);
    step();
    idle_chk("w1011_end");
`ifdef PISO_PARITY_EN
    chk4("capture_chain", cap, 4'b0111);
`else
    chk4("capture_chain", cap, 4'b1011);
`endif

    // Back-to-back A then 5 with load_valid held
    bus.load_valid = 1'b1;
    bus.din        = 4'hA;
    word_bits("wA", 4'hA, 1'b1, 4'h5);
    word_bits("w5", 4'h5, 1'b0, 4'h0);
    step();
    idle_chk("b2b_end");

    // Stall: a word offered mid-flight must be ignored
    bus.load_valid = 1'b1;
    bus.din        = 4'b0110;
    step();
    bus.load_valid = 1'b0;
    chk("stall_b0", bus.sdo, 1'b0);
    step();
    bus.load_valid = 1'b1;
    bus.din        = 4'hF;
    chk("stall_b1", bus.sdo, 1'b1);
    chk("stall_ready", bus.load_ready, 1'b0);
    step();
    bus.load_valid = 1'b0;
    chk("stall_b2", bus.sdo, 1'b1);
    step();
    chk("stall_b3", bus.sdo, 1'b0);
    chk("stall_done", bus.done, !PAR_EN);
`ifdef PISO_PARITY_EN
    step();
    chk("stall_par_sdo", bus.sdo, 1'b0);
    chk("stall_par_done", bus.done, 1'b1);
`endif
    step();
    idle_chk("stall_end");

    // Asynchronous reset in the middle of 4'hC
    bus.load_valid = 1'b1;
    bus.din        = 4'hC;
    step();
    bus.load_valid = 1'b0;
    chk("rst_b0", bus.sdo, 1'b1);
    step();
    chk("rst_b1", bus.sdo, 1'b1);
    chk("rst_b1_busy", bus.busy, 1'b1);
    #2;
    r = 1'b1;
    #1;
    idle_chk("rst_async");
    repeat (2) step();
    r = 1'b0;
    repeat (2) step();
    idle_chk("rst_no_resume");

    bus.load_valid = 1'b1;
    bus.din        = 4'b1011;
    word_bits("post_rst", 4'b1011, 1'b0, 4'h0);
    step();
    idle_chk("post_rst_end");

`ifdef PISO_PARITY_EN
    bus.load_valid = 1'b1;
    bus.din        = 4'b0111;
    word_bits("par0111", 4'b0111, 1'b0, 4'h0);
    step();
    idle_chk("par0111_end");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
